// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin arbiter sharing one combinational ALU between two requesters
module ula_arbitro #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valido,
  input  logic               req1_valido,
  input  logic [2:0]         req0_sel,
  input  logic [2:0]         req1_sel,
  input  logic [LARGURA-1:0] req0_x,
  input  logic [LARGURA-1:0] req0_y,
  input  logic [LARGURA-1:0] req1_x,
  input  logic [LARGURA-1:0] req1_y,
  output logic               req0_pronto,
  output logic               req1_pronto,
  output logic [2:0]         ula_selecao,
  output logic [LARGURA-1:0] ula_X,
  output logic [LARGURA-1:0] ula_Y,
  input  logic [LARGURA-1:0] ula_resultado,
  input  logic               ula_flag_N,
  input  logic               ula_flag_Z,
  output logic               resp_valido,
  output logic               resp_id,
  output logic [LARGURA-1:0] resp_resultado,
  output logic               resp_flag_N,
  output logic               resp_flag_Z,
  output logic               resp_erro,
  output logic [15:0]        contador_ops
);
  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;
  estado_t estado, proximo;
  logic ponteiro, op_id, g0, g1, aceita, id, div_zero;
  logic [2:0] sel;
  logic [LARGURA-1:0] x, y;
  always_comb begin
    g0 = req0_valido && (!req1_valido || !ponteiro);
    g1 = req1_valido && (!req0_valido || ponteiro);
    req0_pronto = estado == OCIOSO && !reset && g0;
    req1_pronto = estado == OCIOSO && !reset && g1;
    aceita = req0_pronto || req1_pronto;
    id = g1;
    sel = id ? req1_sel : req0_sel;
    x = id ? req1_x : req0_x;
    y = id ? req1_y : req0_y;
    div_zero = sel == 3'b110 && y == '0;
    resp_valido = estado == RESPONDE && !reset;
    proximo = estado == OCIOSO ? (aceita ? (div_zero ? RESPONDE : EXECUTA) : OCIOSO) :
              estado == EXECUTA ? RESPONDE : OCIOSO;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      ponteiro <= 1'b0;
      op_id <= 1'b0;
      resp_id <= 1'b0;
      resp_resultado <= '0;
      resp_flag_N <= 1'b0;
      resp_flag_Z <= 1'b0;
      resp_erro <= 1'b0;
      contador_ops <= '0;
      ula_selecao <= '0;
      ula_X <= '0;
      ula_Y <= '0;
    end else begin
      estado <= proximo;
      if (aceita) begin
        ponteiro <= !id;
        op_id <= id;
        if (div_zero) begin
          resp_id <= id;
          resp_resultado <= '0;
          resp_flag_N <= 1'b0;
          resp_flag_Z <= 1'b1;
          resp_erro <= 1'b1;
        end else begin
          ula_selecao <= sel;
          ula_X <= x;
          ula_Y <= y;
        end
      end
      if (estado == EXECUTA) begin
        resp_id <= op_id;
        resp_resultado <= ula_resultado;
        resp_flag_N <= ula_flag_N;
        resp_flag_Z <= ula_flag_Z;
        resp_erro <= 1'b0;
      end
      if (estado == RESPONDE) contador_ops <= contador_ops + 16'd1;
    end
  end
endmodule

// File: tb/tb_ula_arbitro.sv
// tb_ula_arbitro: directed self-checking bench for ula_arbitro with a behavioural ALU
module tb_ula_arbitro;
  localparam int W = 32;
  logic clock = 1'b0;
  logic reset;
  logic req0_valido, req1_valido, req0_pronto, req1_pronto;
  logic [2:0] req0_sel, req1_sel, ula_selecao;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y, ula_X, ula_Y, ula_resultado, resp_resultado;
  logic ula_flag_N, ula_flag_Z, resp_valido, resp_id, resp_flag_N, resp_flag_Z, resp_erro;
  logic [15:0] contador_ops;
  int vecs = 0;
  int errs = 0;
  ula_arbitro #(.LARGURA(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valido(req0_valido), .req1_valido(req1_valido),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
    .req0_pronto(req0_pronto), .req1_pronto(req1_pronto),
    .ula_selecao(ula_selecao), .ula_X(ula_X), .ula_Y(ula_Y),
    .ula_resultado(ula_resultado), .ula_flag_N(ula_flag_N), .ula_flag_Z(ula_flag_Z),
    .resp_valido(resp_valido), .resp_id(resp_id), .resp_resultado(resp_resultado),
    .resp_flag_N(resp_flag_N), .resp_flag_Z(resp_flag_Z), .resp_erro(resp_erro),
    .contador_ops(contador_ops)
  );
  always #5 clock = ~clock;
  always_comb begin
    ula_resultado = '0;
    case (ula_selecao)
      3'b000: ula_resultado = ula_X;
      3'b001: ula_resultado = ula_X + ula_Y;
      3'b010: ula_resultado = ula_X - ula_Y;
      3'b011: ula_resultado = ula_X & ula_Y;
      3'b100: ula_resultado = ula_X | ula_Y;
      3'b101: ula_resultado = ula_X * ula_Y;
      3'b110: ula_resultado = (ula_Y == '0) ? '0 : W'($signed(ula_X) / $signed(ula_Y));
      default: ula_resultado = ~ula_X;
    endcase
  end
  assign ula_flag_N = ula_resultado[W-1];
  assign ula_flag_Z = ula_resultado == '0;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic v0, input logic [2:0] s0, input logic [W-1:0] x0, y0,
                       input logic v1, input logic [2:0] s1, input logic [W-1:0] x1, y1);
    req0_valido = v0; req0_sel = s0; req0_x = x0; req0_y = y0;
    req1_valido = v1; req1_sel = s1; req1_x = x1; req1_y = y1;
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    drive(1, 3'd1, 1, 1, 1, 3'd1, 2, 2);
    tick; tick;
    vecs++; if (req0_pronto !== 1'b0 || req1_pronto !== 1'b0) begin errs++; $display("FAIL reset_pronto: got %b%b want 00", req0_pronto, req1_pronto); end
    vecs++; if (resp_valido !== 1'b0) begin errs++; $display("FAIL reset_resp_valido: got %b want 0", resp_valido); end
    vecs++; if (contador_ops !== 16'h0) begin errs++; $display("FAIL reset_contador: got %h want 0000", contador_ops); end
    vecs++; if (ula_selecao !== 3'b0 || ula_X !== '0 || ula_Y !== '0) begin errs++; $display("FAIL reset_ula: got %b %h %h want 000 0 0", ula_selecao, ula_X, ula_Y); end
    vecs++; if (resp_resultado !== '0 || resp_id !== 1'b0 || resp_erro !== 1'b0 || resp_flag_Z !== 1'b0) begin errs++; $display("FAIL reset_resp: got %h %b %b %b want 0 0 0 0", resp_resultado, resp_id, resp_erro, resp_flag_Z); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick;
  endtask
  task automatic test_add_req0;
    drive(1, 3'b001, 7, 5, 0, 0, 0, 0);
    vecs++; if (req0_pronto !== 1'b1 || req1_pronto !== 1'b0) begin errs++; $display("FAIL add_pronto: got %b%b want 10", req0_pronto, req1_pronto); end
    tick;
    vecs++; if (req0_pronto !== 1'b0 || resp_valido !== 1'b0) begin errs++; $display("FAIL add_busy: got pronto %b valido %b want 0 0", req0_pronto, resp_valido); end
    vecs++; if (ula_selecao !== 3'b001 || ula_X !== 7 || ula_Y !== 5) begin errs++; $display("FAIL add_ula_ops: got %b %0d %0d want 001 7 5", ula_selecao, ula_X, ula_Y); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    vecs++; if (resp_valido !== 1'b1 || resp_resultado !== 32'd12 || resp_flag_N !== 1'b0 || resp_flag_Z !== 1'b0 || resp_id !== 1'b0 || resp_erro !== 1'b0) begin errs++; $display("FAIL add_resp: got v%b r%h N%b Z%b id%b e%b want v1 r0000000c N0 Z0 id0 e0", resp_valido, resp_resultado, resp_flag_N, resp_flag_Z, resp_id, resp_erro); end
    tick;
    vecs++; if (resp_valido !== 1'b0 || contador_ops !== 16'd1) begin errs++; $display("FAIL add_after: got v%b cnt %0d want v0 cnt 1", resp_valido, contador_ops); end
    vecs++; if (resp_resultado !== 32'd12) begin errs++; $display("FAIL add_hold: got %h want 0000000c", resp_resultado); end
  endtask
  task automatic test_sub_req1;
    drive(0, 0, 0, 0, 1, 3'b010, 3, 8);
    vecs++; if (req0_pronto !== 1'b0 || req1_pronto !== 1'b1) begin errs++; $display("FAIL sub_pronto: got %b%b want 01", req0_pronto, req1_pronto); end
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    vecs++; if (resp_valido !== 1'b1 || resp_resultado !== 32'hFFFFFFFB || resp_flag_N !== 1'b1 || resp_flag_Z !== 1'b0 || resp_id !== 1'b1) begin errs++; $display("FAIL sub_resp: got v%b r%h N%b Z%b id%b want v1 rfffffffb N1 Z0 id1", resp_valido, resp_resultado, resp_flag_N, resp_flag_Z, resp_id); end
    tick;
    vecs++; if (contador_ops !== 16'd2) begin errs++; $display("FAIL sub_contador: got %0d want 2", contador_ops); end
  endtask
  task automatic test_round_robin;
    drive(1, 3'b001, 1, 2, 1, 3'b100, 4, 1);
    for (int k = 0; k < 4; k++) begin
      vecs++; if (req0_pronto !== (k % 2 == 0) || req1_pronto !== (k % 2 == 1)) begin errs++; $display("FAIL rr_grant%0d: got %b%b want %b%b", k, req0_pronto, req1_pronto, k % 2 == 0, k % 2 == 1); end
      tick;
      vecs++; if (req0_pronto !== 1'b0 || req1_pronto !== 1'b0) begin errs++; $display("FAIL rr_busy%0d: got %b%b want 00", k, req0_pronto, req1_pronto); end
      tick;
      vecs++; if (resp_valido !== 1'b1 || resp_id !== 1'(k % 2) || resp_resultado !== ((k % 2 == 0) ? 32'd3 : 32'd5)) begin errs++; $display("FAIL rr_resp%0d: got v%b id%b r%0d want v1 id%0d r%0d", k, resp_valido, resp_id, resp_resultado, k % 2, (k % 2 == 0) ? 3 : 5); end
      vecs++; if (req0_pronto !== 1'b0 || req1_pronto !== 1'b0) begin errs++; $display("FAIL rr_resp_busy%0d: got %b%b want 00", k, req0_pronto, req1_pronto); end
      tick;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (contador_ops !== 16'd6) begin errs++; $display("FAIL rr_contador: got %0d want 6", contador_ops); end
  endtask
  task automatic test_divzero;
    drive(1, 3'b110, 9, 0, 0, 0, 0, 0);
    vecs++; if (req0_pronto !== 1'b1) begin errs++; $display("FAIL dz_pronto: got %b want 1", req0_pronto); end
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (resp_valido !== 1'b1 || resp_erro !== 1'b1 || resp_resultado !== '0 || resp_flag_Z !== 1'b1 || resp_flag_N !== 1'b0 || resp_id !== 1'b0) begin errs++; $display("FAIL dz_resp: got v%b e%b r%h Z%b N%b id%b want v1 e1 r0 Z1 N0 id0", resp_valido, resp_erro, resp_resultado, resp_flag_Z, resp_flag_N, resp_id); end
    vecs++; if (ula_selecao !== 3'b100 || ula_X !== 4 || ula_Y !== 1) begin errs++; $display("FAIL dz_ula_hold: got %b %0d %0d want 100 4 1", ula_selecao, ula_X, ula_Y); end
    tick;
    vecs++; if (resp_valido !== 1'b0 || contador_ops !== 16'd7) begin errs++; $display("FAIL dz_after: got v%b cnt %0d want v0 cnt 7", resp_valido, contador_ops); end
    drive(0, 0, 0, 0, 1, 3'b110, -20, 3);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (resp_valido !== 1'b0) begin errs++; $display("FAIL div_latency: got v%b want 0", resp_valido); end
    tick;
    vecs++; if (resp_valido !== 1'b1 || resp_resultado !== 32'hFFFFFFFA || resp_erro !== 1'b0 || resp_flag_N !== 1'b1 || resp_id !== 1'b1) begin errs++; $display("FAIL div_resp: got v%b r%h e%b N%b id%b want v1 rfffffffa e0 N1 id1", resp_valido, resp_resultado, resp_erro, resp_flag_N, resp_id); end
    tick;
  endtask
  task automatic test_reset_abort;
    drive(0, 0, 0, 0, 1, 3'b001, 2, 2);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick;
    vecs++; if (resp_valido !== 1'b0 || contador_ops !== 16'd0 || ula_X !== '0) begin errs++; $display("FAIL abort_exec: got v%b cnt %0d X %0d want v0 cnt 0 X 0", resp_valido, contador_ops, ula_X); end
    reset = 1'b0;
    drive(1, 3'b001, 1, 1, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    reset = 1'b1;
    #1;
    vecs++; if (resp_valido !== 1'b0) begin errs++; $display("FAIL abort_resp_pulse: got %b want 0", resp_valido); end
    tick;
    vecs++; if (contador_ops !== 16'd0) begin errs++; $display("FAIL abort_resp_cnt: got %0d want 0", contador_ops); end
    reset = 1'b0;
    drive(1, 3'b001, 10, 20, 1, 3'b001, 5, 5);
    vecs++; if (req0_pronto !== 1'b1 || req1_pronto !== 1'b0) begin errs++; $display("FAIL abort_ptr: got %b%b want 10", req0_pronto, req1_pronto); end
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    vecs++; if (resp_valido !== 1'b1 || resp_resultado !== 32'd30 || resp_id !== 1'b0) begin errs++; $display("FAIL abort_next: got v%b r%0d id%b want v1 r30 id0", resp_valido, resp_resultado, resp_id); end
    tick;
    vecs++; if (contador_ops !== 16'd1) begin errs++; $display("FAIL abort_next_cnt: got %0d want 1", contador_ops); end
  endtask
  task automatic test_wrap;
    force dut.contador_ops = 16'hFFFE;
    #1;
    release dut.contador_ops;
    for (int k = 0; k < 2; k++) begin
      drive(1, 3'b110, 1, 0, 0, 0, 0, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick;
      vecs++; if (contador_ops !== ((k == 0) ? 16'hFFFF : 16'h0000)) begin errs++; $display("FAIL wrap%0d: got %h want %h", k, contador_ops, (k == 0) ? 16'hFFFF : 16'h0000); end
    end
  endtask
  initial begin
    test_reset;
    test_add_req0;
    test_sub_req1;
    test_round_robin;
    test_divzero;
    test_reset_abort;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
